// File: rtl/servo_ramp_sequencer_if.sv
// -----------------------------------------------------------------------------
// servo_ramp_sequencer_if
// Wishbone classic bus bundle. The sequencer uses one instance as its host
// slave port and a second instance as its master port toward servo_controller.
//
// Handshake: the initiator raises cyc and stb together and holds them, along
// with we/sel/adr/dat_w, until it samples ack=1 on a rising clock edge. It
// drops them on that same edge. The target raises ack for exactly one cycle
// per transfer. Read data on dat_r is only meaningful while ack is high.
//
// Signals:
//   cyc, stb, we : initiator strobes
//   sel[3:0]     : byte selects
//   adr[31:0]    : address
//   dat_w[31:0]  : write data, initiator to target
//   dat_r[31:0]  : read data, target to initiator
//   ack          : target acknowledge
// -----------------------------------------------------------------------------
interface servo_ramp_sequencer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/servo_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// servo_ramp_sequencer
// Slew-limited motion sequencer. The host programs TARGET, STEP and INTERVAL
// over the Wishbone slave port. After a go command the block walks the
// servo_controller PWM width register toward TARGET through the Wishbone
// master port, one bounded step per interval.
//
// Ports:
//   wb_clk, wb_rst : clock, synchronous active-high reset
//   wbs            : host slave port (dat_w = wbs_dat_i, dat_r = wbs_dat_o)
//   wbm            : master port to servo_controller (dat_w = wbm_dat_o)
//   busy           : high whenever the FSM is not IDLE
//   done_irq       : level copy of STATUS.done
//   o_dbg_state    : current FSM state encoding
//
// Register map (wbs.adr[4:2]):
//   0 CTRL     bit0 enable, bit1 go (pulse), bit2 abort (pulse)
//   1 TARGET   clamped into [WIDTH_MIN, WIDTH_MAX] on write
//   2 STEP     0 behaves as 1
//   3 INTERVAL idle cycles between a master ack and the next strobe
//   4 STATUS   bit0 busy, bit1 done (W1C), bit2 err (W1C)
//   5 CURRENT  last acknowledged width
// -----------------------------------------------------------------------------
module servo_ramp_sequencer #(
  parameter logic [31:0] PWM_REG_ADDR = 32'h0000_0004,
  parameter logic [31:0] RESET_WIDTH  = 32'd150000,
  parameter logic [31:0] WIDTH_MIN    = 32'd100000,
  parameter logic [31:0] WIDTH_MAX    = 32'd200000,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst,
  servo_ramp_sequencer_if.slave         wbs,
  servo_ramp_sequencer_if.master        wbm,
  output logic                          busy,
  output logic                          done_irq,
  output logic [1:0]                    o_dbg_state
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_INTERVAL = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_wbs_ack;
  logic [31:0]     r_wbs_dat;
  logic            r_enable;
  logic            r_go;
  logic            r_stop;
  logic            r_done;
  logic            r_err;
  logic [31:0]     r_target;
  logic [31:0]     r_step;
  logic [31:0]     r_interval;
  logic [31:0]     r_current;
  logic [31:0]     r_next;
  logic [31:0]     r_cnt;
  logic [TO_W-1:0] r_to_cnt;

  logic            w_req;
  logic            w_wr;
  logic [2:0]      w_sel;
  logic            w_ctrl_wr;
  logic            w_status_wr;
  logic            w_go_cmd;
  logic            w_abort_cmd;
  logic            w_stop;
  logic            w_busy;
  logic [31:0]     w_rdata;
  logic            w_enter_write;
  logic            w_ack_ok;
  logic            w_set_done;
  logic            w_set_err;
  logic            w_load_cnt;
  logic            w_unused;

  function automatic logic [31:0] f_clamp(input logic [31:0] v);
    if (v < WIDTH_MIN)      f_clamp = WIDTH_MIN;
    else if (v > WIDTH_MAX) f_clamp = WIDTH_MAX;
    else                    f_clamp = v;
  endfunction

  // One step from cur toward tgt, never past tgt. STEP of 0 moves by 1.
  function automatic logic [31:0] f_next(input logic [31:0] tgt,
                                         input logic [31:0] cur,
                                         input logic [31:0] step);
    logic [31:0] eff;
    logic [31:0] diff;
    eff = (step == 32'd0) ? 32'd1 : step;
    if (tgt >= cur) begin
      diff   = tgt - cur;
      f_next = cur + ((diff < eff) ? diff : eff);
    end else begin
      diff   = cur - tgt;
      f_next = cur - ((diff < eff) ? diff : eff);
    end
  endfunction

  // Slave decode. A new request is only taken when ack is low, which
  // gives exactly one ack cycle per transfer.
  assign w_req       = wbs.cyc & wbs.stb & ~r_wbs_ack;
  assign w_wr        = w_req & wbs.we;
  assign w_sel       = wbs.adr[4:2];
  assign w_ctrl_wr   = w_wr && (w_sel == 3'd0);
  assign w_status_wr = w_wr && (w_sel == 3'd4);
  // Abort bit beats go; clearing enable is treated as an abort.
  assign w_abort_cmd = w_ctrl_wr && (wbs.dat_w[2] || !wbs.dat_w[0]);
  assign w_go_cmd    = w_ctrl_wr && wbs.dat_w[1] && !wbs.dat_w[2];
  assign w_stop      = r_stop | w_abort_cmd;
  assign w_busy      = (r_state != S_IDLE);

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      3'd0:    w_rdata = {31'd0, r_enable};
      3'd1:    w_rdata = r_target;
      3'd2:    w_rdata = r_step;
      3'd3:    w_rdata = r_interval;
      3'd4:    w_rdata = {29'd0, r_err, r_done, w_busy};
      3'd5:    w_rdata = r_current;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_wbs_ack  <= 1'b0;
      r_wbs_dat  <= '0;
      r_enable   <= 1'b0;
      r_go       <= 1'b0;
      r_target   <= RESET_WIDTH;
      r_step     <= 32'd1;
      r_interval <= 32'd100000;
    end else begin
      r_wbs_ack <= w_req;
      r_wbs_dat <= w_req ? w_rdata : '0;
      // go acts one cycle after its ack edge so the strobe starts at N+1.
      r_go      <= w_go_cmd;
      if (w_wr) begin
        case (w_sel)
          3'd0:    r_enable   <= wbs.dat_w[0];
          3'd1:    r_target   <= f_clamp(wbs.dat_w);
          3'd2:    r_step     <= wbs.dat_w;
          3'd3:    r_interval <= wbs.dat_w;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_enter_write = 1'b0;
    w_ack_ok      = 1'b0;
    w_set_done    = 1'b0;
    w_set_err     = 1'b0;
    w_load_cnt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_go && r_enable) begin
          if (r_target != r_current) begin
            w_state_nxt   = S_WRITE;
            w_enter_write = 1'b1;
          end else begin
            w_set_done = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (wbm.ack) begin
          w_ack_ok = 1'b1;
          if (w_stop) begin
            w_state_nxt = S_IDLE;
          end else if (r_next == r_target) begin
            w_state_nxt = S_IDLE;
            w_set_done  = 1'b1;
          end else begin
            w_state_nxt = S_INTERVAL;
            w_load_cnt  = 1'b1;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_set_err   = 1'b1;
        end
      end
      S_INTERVAL: begin
        // Leaving at count <= 1 gives max(INTERVAL, 1) idle cycles.
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt <= 32'd1) begin
          w_state_nxt   = S_WRITE;
          w_enter_write = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_current <= RESET_WIDTH;
      r_next    <= '0;
      r_cnt     <= '0;
      r_to_cnt  <= '0;
      r_stop    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // NEXT is latched on WRITE entry, so a TARGET write landing on the
      // same edge is seen only at the following WRITE entry.
      if (w_enter_write) begin
        r_next   <= f_next(r_target, r_current, r_step);
        r_to_cnt <= '0;
      end else if (r_state == S_WRITE) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (w_ack_ok) r_current <= r_next;

      if (w_load_cnt)                                r_cnt <= r_interval;
      else if (r_state == S_INTERVAL && r_cnt != 0)  r_cnt <= r_cnt - 32'd1;

      // Abort during WRITE is remembered until the transfer completes.
      if (w_state_nxt == S_IDLE) r_stop <= 1'b0;
      else if (w_abort_cmd)      r_stop <= 1'b1;

      if (w_set_done)                          r_done <= 1'b1;
      else if (w_status_wr && wbs.dat_w[1])    r_done <= 1'b0;

      if (w_set_err)                           r_err <= 1'b1;
      else if (w_status_wr && wbs.dat_w[2])    r_err <= 1'b0;
    end
  end

  assign wbs.ack     = r_wbs_ack;
  assign wbs.dat_r   = r_wbs_dat;
  assign wbm.cyc     = (r_state == S_WRITE);
  assign wbm.stb     = (r_state == S_WRITE);
  assign wbm.we      = (r_state == S_WRITE);
  assign wbm.sel     = 4'hF;
  assign wbm.adr     = PWM_REG_ADDR;
  assign wbm.dat_w   = r_next;
  assign busy        = w_busy;
  assign done_irq    = r_done;
  assign o_dbg_state = r_state;

  assign w_unused = ^{wbs.sel, wbs.adr[31:5], wbs.adr[1:0], wbm.dat_r};

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
module tb_servo_ramp_sequencer;

  localparam logic [31:0] PWM_ADDR = 32'h0000_0004;
  localparam logic [31:0] RESET_W  = 32'd150000;
  localparam logic [31:0] W_MIN    = 32'd100000;
  localparam logic [31:0] W_MAX    = 32'd200000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic       done_irq;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  servo_ramp_sequencer_if wbs_bus ();
  servo_ramp_sequencer_if wbm_bus ();

  servo_ramp_sequencer dut (
    .wb_clk      (clk),
    .wb_rst      (rst),
    .wbs         (wbs_bus),
    .wbm         (wbm_bus),
    .busy        (busy),
    .done_irq    (done_irq),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard state
  logic [31:0] exp_mw_q[$];
  logic [31:0] exp_rd_q[$];
  string       rd_name_q[$];
  int          mw_count     = 0;
  logic [31:0] exp_gap      = 32'd1;
  logic        expect_final = 1'b0;
  logic        resp_en      = 1'b1;

  // reference model of the programmed registers
  logic [31:0] m_target  = RESET_W;
  logic [31:0] m_current = RESET_W;
  logic [31:0] m_step    = 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [31:0] m_clamp(input logic [31:0] v);
    if (v < W_MIN) return W_MIN;
    if (v > W_MAX) return W_MAX;
    return v;
  endfunction

  // Expected waypoints of a whole ramp, computed in wide arithmetic.
  task automatic model_push(input int max_n, output int n);
    longint cur, tgt, eff;
    cur = longint'(m_current);
    tgt = longint'(m_target);
    eff = (m_step == 0) ? 64'sd1 : longint'(m_step);
    n = 0;
    while (cur != tgt && n < max_n) begin
      if (tgt > cur) cur = (cur + eff > tgt) ? tgt : cur + eff;
      else           cur = (cur - eff < tgt) ? tgt : cur - eff;
      exp_mw_q.push_back(cur[31:0]);
      n++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic we, input logic [2:0] rsel, input logic [31:0] data,
                         input string name, input logic [31:0] exp);
    logic got;
    @(negedge clk);
    wbs_bus.cyc   = 1'b1;
    wbs_bus.stb   = 1'b1;
    wbs_bus.we    = we;
    wbs_bus.sel   = 4'hF;
    wbs_bus.adr   = {27'd0, rsel, 2'b00};
    wbs_bus.dat_w = data;
    if (!we) begin
      exp_rd_q.push_back(exp);
      rd_name_q.push_back(name);
    end
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if (wbs_bus.ack) got = 1'b1;
    end
    wbs_bus.cyc = 1'b0;
    wbs_bus.stb = 1'b0;
    if (!got) fail_now("slave_ack_wait");
  endtask

  task automatic host_write(input logic [2:0] rsel, input logic [31:0] data);
    wb_xfer(1'b1, rsel, data, "", 32'd0);
  endtask

  task automatic host_read(input logic [2:0] rsel, input logic [31:0] exp, input string name);
    wb_xfer(1'b0, rsel, 32'd0, name, exp);
  endtask

  task automatic wait_cycles_no_cyc(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(name, {31'd0, wbm_bus.cyc}, 32'd0);
    end
  endtask

  task automatic run_move(input logic [31:0] tgt, input logic [31:0] step,
                          input logic [31:0] ivl, input string tag);
    int n;
    int base;
    host_write(3'd2, step);
    m_step = step;
    host_write(3'd3, ivl);
    host_write(3'd1, tgt);
    m_target = m_clamp(tgt);
    host_write(3'd4, 32'h2);
    model_push(1000, n);
    exp_gap      = (ivl == 0) ? 32'd1 : ivl;
    expect_final = (n > 0);
    base         = mw_count;
    host_write(3'd0, 32'h3);
    @(negedge clk);
    if (n > 0) begin
      check({tag, "_stb_after_go"}, {31'd0, wbm_bus.stb}, 32'd1);
    end else begin
      check({tag, "_noop_done"}, {31'd0, done_irq}, 32'd1);
      check({tag, "_noop_cyc"}, {31'd0, wbm_bus.cyc}, 32'd0);
    end
    for (int k = 0; k < 5000 && (busy || exp_mw_q.size() != 0); k++) @(negedge clk);
    if (busy || exp_mw_q.size() != 0) fail_now({tag, "_run_end"});
    repeat (2) @(negedge clk);
    check({tag, "_write_count"}, mw_count - base, n);
    m_current = m_target;
    host_read(3'd5, m_current, {tag, "_current"});
    host_read(3'd4, 32'h2, {tag, "_status"});
  endtask

  // ---------------- servo_controller responder ----------------
  initial begin
    int lat;
    lat = 0;
    wbm_bus.ack   = 1'b0;
    wbm_bus.dat_r = '0;
    forever begin
      @(negedge clk);
      if (wbm_bus.ack) begin
        wbm_bus.ack = 1'b0;
      end else if (wbm_bus.cyc && wbm_bus.stb && resp_en) begin
        if (lat == 0) begin
          wbm_bus.ack = 1'b1;
          lat = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    logic        in_txn;
    logic        gap_armed;
    int          idle_cnt;
    logic [31:0] txn_dat;
    in_txn    = 1'b0;
    gap_armed = 1'b0;
    idle_cnt  = 0;
    txn_dat   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (wbm_bus.cyc && wbm_bus.stb) begin
        if (!in_txn) begin
          in_txn  = 1'b1;
          txn_dat = wbm_bus.dat_w;
          if (gap_armed) begin
            check("interval_gap", idle_cnt, exp_gap);
            gap_armed = 1'b0;
          end
        end else begin
          check("wbm_dat_stable", wbm_bus.dat_w, txn_dat);
        end
        if (wbm_bus.ack) begin
          mw_count++;
          in_txn = 1'b0;
          check("wbm_we", {31'd0, wbm_bus.we}, 32'd1);
          check("wbm_sel", {28'd0, wbm_bus.sel}, 32'hF);
          check("wbm_adr", wbm_bus.adr, PWM_ADDR);
          if (exp_mw_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_master_write: got %0d, expected no write", wbm_bus.dat_w);
          end else begin
            check("master_write_value", wbm_bus.dat_w, exp_mw_q.pop_front());
            if (exp_mw_q.size() > 0) begin
              gap_armed = 1'b1;
              idle_cnt  = 0;
            end else if (expect_final) begin
              expect_final = 1'b0;
              @(negedge clk);
              #1;
              check("busy_after_final_ack", {31'd0, busy}, 32'd0);
              check("done_after_final_ack", {31'd0, done_irq}, 32'd1);
            end
          end
        end
      end else begin
        in_txn = 1'b0;
        idle_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (wbs_bus.ack && !wbs_bus.we) begin
        if (exp_rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read_ack: got %0d, expected no read", wbs_bus.dat_r);
        end else begin
          check(rd_name_q.pop_front(), wbs_bus.dat_r, exp_rd_q.pop_front());
        end
      end else if (!wbs_bus.ack && !rst) begin
        check("wbs_dat_idle_zero", wbs_bus.dat_r, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int cnt;
    int mode;
    logic [31:0] r_tgt;
    logic [31:0] r_stp;
    logic [31:0] r_ivl;
    longint d;

    wbs_bus.cyc   = 1'b0;
    wbs_bus.stb   = 1'b0;
    wbs_bus.we    = 1'b0;
    wbs_bus.sel   = 4'h0;
    wbs_bus.adr   = '0;
    wbs_bus.dat_w = '0;

    // reset
    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles_no_cyc(200, "no_cyc_after_reset");
    check("rst_wbs_ack", {31'd0, wbs_bus.ack}, 32'd0);
    check("rst_wbs_dat", wbs_bus.dat_r, 32'd0);
    check("rst_wbm_stb", {31'd0, wbm_bus.stb}, 32'd0);
    check("rst_wbm_we", {31'd0, wbm_bus.we}, 32'd0);
    check("rst_wbm_dat", wbm_bus.dat_w, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_irq", {31'd0, done_irq}, 32'd0);
    host_read(3'd5, RESET_W, "rst_current");
    host_read(3'd1, RESET_W, "rst_target");
    host_read(3'd2, 32'd1, "rst_step");
    host_read(3'd3, 32'd100000, "rst_interval");
    host_read(3'd0, 32'd0, "rst_ctrl");
    host_read(3'd4, 32'd0, "rst_status");
    host_write(3'd6, 32'hFFFF);
    host_read(3'd6, 32'd0, "unmapped_6");
    host_read(3'd7, 32'd0, "unmapped_7");

    // no-op go: TARGET == CURRENT
    run_move(RESET_W, 32'd1, 32'd5, "noop");
    host_write(3'd4, 32'h2);
    host_read(3'd4, 32'd0, "done_w1c");

    // disabled go
    host_write(3'd0, 32'h2);
    wait_cycles_no_cyc(20, "disabled_go_cyc");
    host_read(3'd4, 32'd0, "disabled_go_status");
    host_read(3'd0, 32'd0, "disabled_go_ctrl");

    // abort after the third ack
    host_write(3'd2, 32'd1000);
    m_step = 32'd1000;
    host_write(3'd3, 32'd50);
    host_write(3'd1, 32'd200000);
    m_target = 32'd200000;
    model_push(3, cnt);
    exp_gap      = 32'd50;
    expect_final = 1'b0;
    base         = mw_count;
    host_write(3'd0, 32'h3);
    for (int k = 0; k < 2000 && mw_count < base + 3; k++) @(negedge clk);
    if (mw_count < base + 3) fail_now("abort_wait_acks");
    host_write(3'd0, 32'h4);
    m_current = 32'd153000;
    repeat (100) @(negedge clk);
    check("abort_write_count", mw_count - base, 32'd3);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done_irq", {31'd0, done_irq}, 32'd0);
    host_read(3'd5, 32'd153000, "abort_current");
    host_read(3'd4, 32'd0, "abort_status");

    // ramp of four writes, last one short
    run_move(m_current + 32'd100, 32'd30, 32'd10, "ramp_up");

    // clamp and large step
    host_write(3'd1, 32'd300000);
    host_read(3'd1, W_MAX, "clamp_high");
    host_write(3'd1, 32'd50000);
    host_read(3'd1, W_MIN, "clamp_low");
    run_move(32'd50000, 32'h10000, 32'd10, "clamp_big_step");

    // ack timeout
    resp_en = 1'b0;
    host_write(3'd2, 32'd1000);
    host_write(3'd1, m_current + 32'd500);
    host_write(3'd4, 32'h2);
    host_write(3'd0, 32'h3);
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (wbm_bus.cyc) cnt++;
      else if (cnt > 0) break;
    end
    check("timeout_cyc_cycles", cnt, 32'd255);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    resp_en = 1'b1;
    host_read(3'd4, 32'h4, "timeout_status");
    host_read(3'd5, m_current, "timeout_current");
    host_write(3'd4, 32'h4);
    host_read(3'd4, 32'd0, "err_w1c");

    // randomized moves
    for (int it = 0; it < 12; it++) begin
      mode  = $urandom_range(0, 3);
      r_ivl = $urandom_range(0, 6);
      if (mode == 0) begin
        r_stp = $urandom_range(20000, 200000);
        r_tgt = $urandom_range(0, 300000);
      end else begin
        r_stp = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 3000);
        d     = (r_stp == 0) ? $urandom_range(0, 20) : $urandom_range(0, r_stp * 20);
        if ($urandom_range(0, 1) == 1) d = -d;
        d     = longint'(m_current) + d;
        r_tgt = d[31:0];
      end
      run_move(r_tgt, r_stp, r_ivl, "random");
    end

    repeat (5) @(negedge clk);
    check("read_queue_drained", exp_rd_q.size(), 32'd0);
    check("write_queue_drained", exp_mw_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
